// File: rtl/dds_wavegen.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | dds_wavegen                                                            |
// | Phase-accumulator DDS generator with quarter-wave sine LUT, four wave  |
// | shapes, amplitude gain and wrap-synchronous config apply.              |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module dds_wavegen #(
    parameter int PHASE_W    = 24,
    parameter int LUT_ADDR_W = 8,
    parameter int OUT_W      = 10,
    parameter int CLK_DIV    = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [PHASE_W-1:0] cfg_freq,
    input  logic [PHASE_W-1:0] cfg_offset,
    input  logic [1:0]         cfg_wave,
    input  logic [7:0]         cfg_amp,
    output logic [OUT_W-1:0]   sample,
    output logic               sample_valid,
    output logic               wrap
);
    localparam int               c_msb     = PHASE_W - 1;
    localparam int               c_div_w   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_div_w-1:0] c_div_max = c_div_w'(CLK_DIV - 1);
    localparam logic [OUT_W-1:0] c_mid     = {1'b1, {(OUT_W-1){1'b0}}};
    localparam int               c_lut_n   = 2**LUT_ADDR_W;
    localparam logic [1:0]       c_wave_sine = 2'd0;
    localparam logic [1:0]       c_wave_tri  = 2'd1;
    localparam logic [1:0]       c_wave_saw  = 2'd2;

    // Elaboration-time sine (Taylor series) used only to fill the LUT constants.
    function automatic real f_sin(input real x);
        real term;
        real sum;
        term = x;
        sum  = x;
        for (int k = 1; k < 12; k++) begin
            term = -term * x * x / ($itor(2 * k) * $itor(2 * k + 1));
            sum  = sum + term;
        end
        return sum;
    endfunction

    logic [OUT_W-2:0] w_lut [c_lut_n];
    for (genvar n = 0; n < c_lut_n; n++) begin : g_lut
        localparam real c_ang = 1.5707963267948966 * ($itor(n) + 0.5) / $itor(c_lut_n);
        localparam int  c_val = $rtoi($itor(2**(OUT_W-1) - 1) * f_sin(c_ang) + 0.5);
        assign w_lut[n] = (OUT_W-1)'(c_val);
    end

    logic [PHASE_W-1:0] r_freq, r_offset, r_sh_freq, r_sh_offset, r_acc;
    logic [1:0]         r_wave, r_sh_wave;
    logic [7:0]         r_amp, r_sh_amp;
    logic               r_pending, r_carry;
    logic [c_div_w-1:0] r_div_cnt;

    logic               w_strobe, w_carry, w_apply, w_accept;
    logic [PHASE_W-1:0] w_acc_next, w_phase;

    assign w_strobe              = en && (r_div_cnt == '0);
    assign {w_carry, w_acc_next} = {1'b0, r_acc} + {1'b0, r_freq};
    assign w_accept              = cfg_valid && !r_pending;
    assign w_apply               = r_pending && (!en || (w_strobe && (w_carry || r_freq == '0)));
    assign w_phase               = r_acc + r_offset;
    assign cfg_ready             = !r_pending;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_freq      <= '0;
            r_offset    <= '0;
            r_wave      <= c_wave_sine;
            r_amp       <= 8'd255;
            r_sh_freq   <= '0;
            r_sh_offset <= '0;
            r_sh_wave   <= c_wave_sine;
            r_sh_amp    <= 8'd255;
            r_pending   <= 1'b0;
            r_acc       <= '0;
            r_carry     <= 1'b0;
            r_div_cnt   <= '0;
        end else begin
            if (!en || r_div_cnt == c_div_max) begin
                r_div_cnt <= '0;
            end else begin
                r_div_cnt <= r_div_cnt + c_div_w'(1);
            end
            if (w_accept) begin
                r_sh_freq   <= cfg_freq;
                r_sh_offset <= cfg_offset;
                r_sh_wave   <= cfg_wave;
                r_sh_amp    <= cfg_amp;
                r_pending   <= 1'b1;
            end else if (w_apply) begin
                r_freq    <= r_sh_freq;
                r_offset  <= r_sh_offset;
                r_wave    <= r_sh_wave;
                r_amp     <= r_sh_amp;
                r_pending <= 1'b0;
            end
            // The carry of this add tags the next strobe's sample as the wrap.
            if (w_strobe) begin
                r_acc   <= w_acc_next;
                r_carry <= w_carry;
            end
        end
    end

    logic               r_s1_valid, r_s1_wrap, r_s2_valid, r_s2_wrap;
    logic [PHASE_W-1:0] r_s1_phase;
    logic [1:0]         r_s1_wave;
    logic [7:0]         r_s1_amp, r_s2_amp;
    logic [OUT_W-1:0]   r_s2_raw, r_sample;
    logic               r_sample_valid, r_wrap;

    logic [1:0]            w_q;
    logic [LUT_ADDR_W-1:0] w_i, w_idx;
    logic [OUT_W-1:0]      w_l, w_t, w_raw;

    assign w_q   = r_s1_phase[c_msb -: 2];
    assign w_i   = r_s1_phase[c_msb-2 -: LUT_ADDR_W];
    assign w_idx = w_q[0] ? ~w_i : w_i;
    assign w_l   = {1'b0, w_lut[w_idx]};
    assign w_t   = r_s1_phase[c_msb-1 -: OUT_W];

    always_comb begin
        w_raw = '0;
        case (r_s1_wave)
            c_wave_sine: w_raw = w_q[1] ? (c_mid - w_l) : (c_mid + w_l);
            c_wave_tri:  w_raw = r_s1_phase[c_msb] ? ~w_t : w_t;
            c_wave_saw:  w_raw = r_s1_phase[c_msb -: OUT_W];
            default:     w_raw = r_s1_phase[c_msb] ? '0 : '1;
        endcase
    end

    logic [OUT_W:0]          w_s;
    logic signed [OUT_W+10:0] w_s_ext, w_g_ext, w_prod, w_shift;
    logic [OUT_W-1:0]        w_out;
    logic                    w_unused;

    // Gain is applied around mid-scale; >>> gives the floor for negative swings.
    assign w_s      = {1'b0, r_s2_raw} - {1'b0, c_mid};
    assign w_s_ext  = {{10{w_s[OUT_W]}}, w_s};
    assign w_g_ext  = {{(OUT_W+2){1'b0}}, {1'b0, r_s2_amp} + 9'd1};
    assign w_prod   = w_s_ext * w_g_ext;
    assign w_shift  = w_prod >>> 8;
    assign w_out    = c_mid + w_shift[OUT_W-1:0];
    assign w_unused = ^{r_s1_phase, w_shift[OUT_W+10:OUT_W]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid     <= 1'b0;
            r_s1_wrap      <= 1'b0;
            r_s1_phase     <= '0;
            r_s1_wave      <= c_wave_sine;
            r_s1_amp       <= 8'd255;
            r_s2_valid     <= 1'b0;
            r_s2_wrap      <= 1'b0;
            r_s2_raw       <= c_mid;
            r_s2_amp       <= 8'd255;
            r_sample       <= c_mid;
            r_sample_valid <= 1'b0;
            r_wrap         <= 1'b0;
        end else begin
            r_s1_valid <= w_strobe;
            if (w_strobe) begin
                r_s1_phase <= w_phase;
                r_s1_wave  <= r_wave;
                r_s1_amp   <= r_amp;
                r_s1_wrap  <= r_carry;
            end
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_raw  <= w_raw;
                r_s2_amp  <= r_s1_amp;
                r_s2_wrap <= r_s1_wrap;
            end
            r_sample_valid <= r_s2_valid;
            r_wrap         <= r_s2_valid && r_s2_wrap;
            if (r_s2_valid) begin
                r_sample <= w_out;
            end
        end
    end

    assign sample       = r_sample;
    assign sample_valid = r_sample_valid;
    assign wrap         = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_dds_wavegen.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_dds_wavegen                                                         |
// | Directed self-checking bench for dds_wavegen (CLK_DIV 1 and 4).        |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_dds_wavegen;
    logic        clk = 1'b0;
    logic        rst_n, en, cfg_valid;
    logic [23:0] cfg_freq, cfg_offset;
    logic [1:0]  cfg_wave;
    logic [7:0]  cfg_amp;

    logic        cfg_ready1, sample_valid1, wrap1;
    logic [9:0]  sample1;
    logic        cfg_ready4, sample_valid4, wrap4;
    logic [9:0]  sample4;

    always #5 clk = ~clk;

    dds_wavegen dut (
        .clk(clk), .rst_n(rst_n), .en(en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready1),
        .cfg_freq(cfg_freq), .cfg_offset(cfg_offset), .cfg_wave(cfg_wave), .cfg_amp(cfg_amp),
        .sample(sample1), .sample_valid(sample_valid1), .wrap(wrap1)
    );

    dds_wavegen #(.CLK_DIV(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .en(en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready4),
        .cfg_freq(cfg_freq), .cfg_offset(cfg_offset), .cfg_wave(cfg_wave), .cfg_amp(cfg_amp),
        .sample(sample4), .sample_valid(sample_valid4), .wrap(wrap4)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        en        = 1'b0;
        cfg_valid = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic configure(input logic [23:0] f, input logic [23:0] o,
                             input logic [1:0] w, input logic [7:0] a);
        cfg_valid  = 1'b1;
        cfg_freq   = f;
        cfg_offset = o;
        cfg_wave   = w;
        cfg_amp    = a;
        tick();
        cfg_valid = 1'b0;
        tick();
    endtask

    task automatic get1(output logic [9:0] s, output logic w, output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!sample_valid1 && lat < 20);
        if (!sample_valid1) check("timeout_dut", 0, 1);
        s = sample1;
        w = wrap1;
    endtask

    task automatic get4(output logic [9:0] s, output logic w, output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!sample_valid4 && lat < 20);
        if (!sample_valid4) check("timeout_dut4", 0, 1);
        s = sample4;
        w = wrap4;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    logic [9:0] s;
    logic       w;
    int         lat;
    int         pulses;
    int exp_sine[8]  = '{514, 1023, 510, 1, 514, 1023, 510, 1};
    int exp_swrap[8] = '{0, 0, 0, 0, 1, 0, 0, 0};
    int exp_wave[4][4] = '{'{514, 1023, 510, 1}, '{0, 512, 1023, 511},
                           '{0, 256, 512, 768}, '{1023, 1023, 0, 0}};
    int exp_amp[4]   = '{513, 767, 511, 256};
    int exp_upd[13]  = '{0, 128, 256, 384, 512, 640, 768, 896, 0, 256, 512, 768, 0};

    initial begin
        rst_n = 1'b0; en = 1'b0; cfg_valid = 1'b0;
        cfg_freq = '0; cfg_offset = '0; cfg_wave = '0; cfg_amp = '0;

        // Reset state
        do_reset();
        check("rst_sample", sample1, 512);
        check("rst_valid", sample_valid1, 0);
        check("rst_wrap", wrap1, 0);
        check("rst_ready", cfg_ready1, 1);
        check("rst_sample4", sample4, 512);

        // Sine, full amplitude
        configure(24'h40_0000, 24'h0, 2'd0, 8'd255);
        en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            get1(s, w, lat);
            if (i == 0) check("sine_latency", lat, 3);
            check($sformatf("sine_s%0d", i), s, exp_sine[i]);
            check($sformatf("sine_wrap%0d", i), w, exp_swrap[i]);
        end

        // Triangle, saw, square
        for (int wv = 1; wv < 4; wv++) begin
            do_reset();
            configure(24'h40_0000, 24'h0, 2'(wv), 8'd255);
            en = 1'b1;
            for (int i = 0; i < 4; i++) begin
                get1(s, w, lat);
                check($sformatf("wave%0d_s%0d", wv, i), s, exp_wave[wv][i]);
            end
        end

        // Half gain
        do_reset();
        configure(24'h40_0000, 24'h0, 2'd0, 8'd127);
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            get1(s, w, lat);
            check($sformatf("amp127_s%0d", i), s, exp_amp[i]);
        end

        // Prescaler of 4, pause and resume
        do_reset();
        configure(24'h40_0000, 24'h0, 2'd0, 8'd255);
        en = 1'b1;
        get4(s, w, lat);
        check("div4_lat0", lat, 3);
        check("div4_s0", s, 514);
        get4(s, w, lat);
        check("div4_period1", lat, 4);
        check("div4_s1", s, 1023);
        en = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (sample_valid4) pulses++;
        end
        check("div4_pause_pulses", pulses, 0);
        check("div4_hold", sample4, 1023);
        en = 1'b1;
        get4(s, w, lat);
        check("div4_resume_lat", lat, 3);
        check("div4_s2", s, 510);
        get4(s, w, lat);
        check("div4_period3", lat, 4);
        check("div4_s3", s, 1);
        get4(s, w, lat);
        check("div4_period4", lat, 4);
        check("div4_s4", s, 514);
        check("div4_wrap4", w, 1);

        // Config update applied at accumulator wrap; second offer ignored
        do_reset();
        configure(24'h20_0000, 24'h0, 2'd2, 8'd255);
        en = 1'b1;
        for (int t = 1; t <= 15; t++) begin
            tick();
            check($sformatf("upd_ready_t%0d", t), cfg_ready1, (t >= 3 && t <= 7) ? 0 : 1);
            check($sformatf("upd_valid_t%0d", t), sample_valid1, (t >= 3) ? 1 : 0);
            if (t >= 3) begin
                check($sformatf("upd_s_t%0d", t), sample1, exp_upd[t-3]);
                check($sformatf("upd_wrap_t%0d", t), wrap1, (t == 11 || t == 15) ? 1 : 0);
            end
            if (t == 2) begin
                cfg_valid = 1'b1; cfg_freq = 24'h40_0000; cfg_wave = 2'd2; cfg_amp = 8'd255;
            end else if (t == 5) begin
                cfg_valid = 1'b1; cfg_freq = 24'h10_0000;
            end else begin
                cfg_valid = 1'b0;
            end
        end

        // Reset mid-run with a pending config
        cfg_valid = 1'b1; cfg_freq = 24'h20_0000; cfg_wave = 2'd0; cfg_amp = 8'd255;
        tick();
        cfg_valid = 1'b0;
        check("mid_pending_ready", cfg_ready1, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        en    = 1'b0;
        check("mid_rst_sample", sample1, 512);
        check("mid_rst_valid", sample_valid1, 0);
        check("mid_rst_wrap", wrap1, 0);
        check("mid_rst_ready", cfg_ready1, 1);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (sample_valid1) pulses++;
        end
        check("mid_rst_no_drain", pulses, 0);
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            get1(s, w, lat);
            if (i == 0) check("mid_rst_lat", lat, 3);
            check($sformatf("mid_rst_s%0d", i), s, 514);
            check($sformatf("mid_rst_wrap%0d", i), w, 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
